// File: rtl/deser_align_seq.sv
// deser_align_seq
// Bring-up sequencer for the 12-channel TI-ROIC LVDS deserializer.
// A run resets the deserializer, loads an IDELAY tap, waits for the delay
// line to settle, starts word alignment and then collects per-channel
// alignment-done flags. If not every enabled channel aligns within the
// timeout, the tap is stepped and the whole attempt is repeated until the
// tap range runs out.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   start_i        one-cycle start request from the register map
//   ch_enable_i    channels that must align (captured on an accepted start)
//   deser_reset_o  deserializer reset, high for RESET_CYC cycles per attempt
//   dly_tap_ld_o   one-cycle IDELAY tap load strobe
//   dly_tap_in_o   tap value, valid while dly_tap_ld_o is high
//   align_start_o  one-cycle word-alignment start pulse
//   align_done_i   per-channel alignment-done levels
//   align_shift_i  per-channel shift, channel i at [i*SHIFT_W +: SHIFT_W]
//   shift_cap_o    shifts captured at success (disabled channels read 0)
//   locked_tap_o   tap in use at success
//   busy_o         run in progress
//   seq_done_o     success level
//   seq_fail_o     failure level
//   fail_mask_o    enabled channels not done at the final timeout
//   attempt_cnt_o  attempts made in the current/last run, saturating at 15
//   state_out_o    FSM state for register readback
module deser_align_seq #(
  parameter int NUM_CH        = 12,
  parameter int SHIFT_W       = 5,
  parameter int TAP_W         = 5,
  parameter int TAP_INIT      = 0,
  parameter int TAP_STEP      = 2,
  parameter int TAP_MAX       = 31,
  parameter int RESET_CYC     = 16,
  parameter int SETTLE_CYC    = 8,
  parameter int ALIGN_TIMEOUT = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [NUM_CH-1:0]         ch_enable_i,
  output logic                      deser_reset_o,
  output logic                      dly_tap_ld_o,
  output logic [TAP_W-1:0]          dly_tap_in_o,
  output logic                      align_start_o,
  input  logic [NUM_CH-1:0]         align_done_i,
  input  logic [NUM_CH*SHIFT_W-1:0] align_shift_i,
  output logic [NUM_CH*SHIFT_W-1:0] shift_cap_o,
  output logic [TAP_W-1:0]          locked_tap_o,
  output logic                      busy_o,
  output logic                      seq_done_o,
  output logic                      seq_fail_o,
  output logic [NUM_CH-1:0]         fail_mask_o,
  output logic [3:0]                attempt_cnt_o,
  output logic [2:0]                state_out_o
);

  // One shared counter serves the reset hold, the settle wait and the
  // alignment timeout; 16 bits covers the largest timeout of 65535.
  localparam int CNT_W = 16;
  localparam int TAP_X = TAP_W + 1;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ALIGN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [TAP_X-1:0] TAP_STEP_X  = TAP_X'(TAP_STEP);
  localparam logic [TAP_X-1:0] TAP_MAX_X   = TAP_X'(TAP_MAX);
  localparam logic [TAP_W-1:0] TAP_INIT_V  = TAP_W'(TAP_INIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_ALIGN  = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6,
    S_FAIL   = 3'd7
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic [TAP_W-1:0]          locked_tap_q, locked_tap_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic [NUM_CH-1:0]         fail_mask_q, fail_mask_d;
  logic [NUM_CH*SHIFT_W-1:0] shift_cap_q, shift_cap_d;
  logic [3:0]                attempt_q, attempt_d;

  logic [NUM_CH*SHIFT_W-1:0] shift_masked;
  logic                      all_aligned;
  logic [TAP_X-1:0]          tap_next;

  // Only enabled channels contribute a shift; the rest capture as zero.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shift_mask
    assign shift_masked[gi*SHIFT_W +: SHIFT_W] =
      mask_q[gi] ? align_shift_i[gi*SHIFT_W +: SHIFT_W] : '0;
  end

  // All enabled channels must be high in the same cycle.
  assign all_aligned = ((align_done_i & mask_q) == mask_q);
  // One extra bit so a step past TAP_MAX is seen instead of wrapping.
  assign tap_next    = {1'b0, tap_q} + TAP_STEP_X;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    locked_tap_d = locked_tap_q;
    mask_d       = mask_q;
    fail_mask_d  = fail_mask_q;
    shift_cap_d  = shift_cap_q;
    attempt_d    = attempt_q;

    case (state_q)
      // DONE and FAIL hold their result but accept a new start exactly
      // like IDLE does.
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          fail_mask_d = '0;
          shift_cap_d = '0;
          cnt_d       = '0;
          if (|ch_enable_i) begin
            mask_d    = ch_enable_i;
            tap_d     = TAP_INIT_V;
            attempt_d = 4'd1;
            state_d   = S_RST;
          end else begin
            // Nothing to align: report failure with an empty mask and
            // no attempts made.
            mask_d    = '0;
            attempt_d = 4'd0;
            state_d   = S_FAIL;
          end
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_ALIGN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ALIGN: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Success is tested first so it wins over a same-cycle timeout.
        if (all_aligned) begin
          shift_cap_d  = shift_masked;
          locked_tap_d = tap_q;
          state_d      = S_DONE;
        end else if (cnt_q == WAIT_LAST) begin
          if (tap_next <= TAP_MAX_X) begin
            tap_d     = tap_next[TAP_W-1:0];
            attempt_d = (attempt_q == 4'hF) ? 4'hF : attempt_q + 4'd1;
            cnt_d     = '0;
            state_d   = S_RST;
          end else begin
            fail_mask_d = mask_q & ~align_done_i;
            state_d     = S_FAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tap_q        <= TAP_INIT_V;
      locked_tap_q <= '0;
      mask_q       <= '0;
      fail_mask_q  <= '0;
      shift_cap_q  <= '0;
      attempt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      locked_tap_q <= locked_tap_d;
      mask_q       <= mask_d;
      fail_mask_q  <= fail_mask_d;
      shift_cap_q  <= shift_cap_d;
      attempt_q    <= attempt_d;
    end
  end

  // Strobes decode straight from the state register so a reset edge
  // drops them immediately.
  assign deser_reset_o = (state_q == S_RST);
  assign dly_tap_ld_o  = (state_q == S_LOAD);
  assign align_start_o = (state_q == S_ALIGN);
  assign busy_o        = (state_q == S_RST) || (state_q == S_LOAD) ||
                         (state_q == S_SETTLE) || (state_q == S_ALIGN) ||
                         (state_q == S_WAIT);
  assign seq_done_o    = (state_q == S_DONE);
  assign seq_fail_o    = (state_q == S_FAIL);
  assign dly_tap_in_o  = tap_q;
  assign locked_tap_o  = locked_tap_q;
  assign shift_cap_o   = shift_cap_q;
  assign fail_mask_o   = fail_mask_q;
  assign attempt_cnt_o = attempt_q;
  assign state_out_o   = state_q;

endmodule

// File: tb/tb_deser_align_seq.sv
// Testbench for deser_align_seq. A deserializer stand-in drives align_done
// in reaction to align_start; a timeline model predicts every output each
// cycle, and directed runs pin the model with hand-computed values.
// ALIGN_TIMEOUT is shortened to keep the full 16-attempt sweep brief.
module tb_deser_align_seq;

  localparam int NUM_CH        = 12;
  localparam int SHIFT_W       = 5;
  localparam int TAP_W         = 5;
  localparam int TAP_INIT      = 0;
  localparam int TAP_STEP      = 2;
  localparam int TAP_MAX       = 31;
  localparam int RESET_CYC     = 16;
  localparam int SETTLE_CYC    = 8;
  localparam int ALIGN_TIMEOUT = 256;
  localparam int SW            = NUM_CH * SHIFT_W;
  // Offsets inside one attempt, counted from its first reset cycle.
  localparam int R  = RESET_CYC;
  localparam int S  = SETTLE_CYC;
  localparam int W0 = R + S + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic [NUM_CH-1:0] align_done = '0;
  logic [SW-1:0]     align_shift = '0;

  logic              deser_reset_o, dly_tap_ld_o, align_start_o;
  logic [TAP_W-1:0]  dly_tap_in_o, locked_tap_o;
  logic [SW-1:0]     shift_cap_o;
  logic              busy_o, seq_done_o, seq_fail_o;
  logic [NUM_CH-1:0] fail_mask_o;
  logic [3:0]        attempt_cnt_o;
  logic [2:0]        state_out_o;

  deser_align_seq #(
    .NUM_CH(NUM_CH), .SHIFT_W(SHIFT_W), .TAP_W(TAP_W), .TAP_INIT(TAP_INIT),
    .TAP_STEP(TAP_STEP), .TAP_MAX(TAP_MAX), .RESET_CYC(RESET_CYC),
    .SETTLE_CYC(SETTLE_CYC), .ALIGN_TIMEOUT(ALIGN_TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .ch_enable_i(ch_enable),
    .deser_reset_o(deser_reset_o), .dly_tap_ld_o(dly_tap_ld_o),
    .dly_tap_in_o(dly_tap_in_o), .align_start_o(align_start_o),
    .align_done_i(align_done), .align_shift_i(align_shift),
    .shift_cap_o(shift_cap_o), .locked_tap_o(locked_tap_o), .busy_o(busy_o),
    .seq_done_o(seq_done_o), .seq_fail_o(seq_fail_o),
    .fail_mask_o(fail_mask_o), .attempt_cnt_o(attempt_cnt_o),
    .state_out_o(state_out_o)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- deserializer stand-in ----------------
  int mode = 0;     // align_done behaviour selected by the current run
  int since = -1;   // cycles since align_start; -1 when no alignment running
  int cur_tap = 0;  // tap most recently loaded into the delay line

  initial begin
    forever begin
      @(negedge clk);
      if (reset || deser_reset_o) since = -1;
      else if (align_start_o) since = 0;
      else if (since >= 0 && since < 1000000) since++;
      if (dly_tap_ld_o) cur_tap = int'(dly_tap_in_o);
      if (since < 0) align_done = '0;
      else begin
        case (mode)
          1: align_done = (since >= 10) ? 12'hFFF : 12'h000;
          2: align_done = (since >= 10) ? ((cur_tap >= 6) ? 12'hFFF : 12'hFDF) : 12'h000;
          3: align_done = (since >= 10) ? 12'hFEF : 12'h000;
          4: align_done = (since >= 10) ? 12'h003 : 12'h000;
          5: align_done = (since >= 20) ? 12'hFFF :
                          (since >= 10) ? ((since % 2 == 1) ? 12'hF00 : 12'h0FF) : 12'h000;
          6: align_done = (since >= ALIGN_TIMEOUT) ? 12'hFFF : 12'h000;
          default: align_done = 12'h000;
        endcase
      end
    end
  end

  // ---------------- pulse monitor ----------------
  int rst_pulses = 0, rst_badlen = 0, ld_pulses = 0, rst_run = 0;
  bit prev_rst = 1'b0, prev_ld = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (deser_reset_o) rst_run++;
      else if (prev_rst) begin
        rst_pulses++;
        if (rst_run != RESET_CYC) rst_badlen++;
        rst_run = 0;
      end
      if (dly_tap_ld_o && !prev_ld) ld_pulses++;
      prev_rst = deser_reset_o;
      prev_ld  = dly_tap_ld_o;
    end
  end

  // ---------------- timeline model ----------------
  // A run is a series of attempts; each attempt is a fixed cycle layout
  // starting at 'base', and only the WAIT tail depends on align_done.
  bit            m_valid = 0, m_run = 0, m_done = 0, m_fail = 0;
  int            t = 0, base = 0, m_tap = TAP_INIT, m_att = 0, m_locked = 0;
  logic [11:0]   m_mask = '0, m_fm = '0;
  logic [SW-1:0] m_shift = '0;

  initial begin
    forever begin
      int mo;
      @(posedge clk);
      // t is the cycle that just ended at this edge
      if (reset) begin
        m_valid = 1; m_run = 0; m_done = 0; m_fail = 0; m_fm = '0;
        m_att = 0; m_shift = '0; m_locked = 0; m_tap = TAP_INIT; m_mask = '0;
      end else if (m_valid && !m_run) begin
        if (start) begin
          m_done = 0; m_fail = 0; m_fm = '0; m_shift = '0;
          if (ch_enable != '0) begin
            m_run = 1; m_mask = ch_enable; m_tap = TAP_INIT; m_att = 1; base = t + 1;
          end else begin
            m_fail = 1; m_att = 0; m_mask = '0;
          end
        end
      end else if (m_run) begin
        mo = t - base;
        if (mo >= W0) begin
          if ((align_done & m_mask) == m_mask) begin
            m_run = 0; m_done = 1; m_locked = m_tap;
            for (int i = 0; i < NUM_CH; i++)
              if (m_mask[i]) m_shift[i*SHIFT_W +: SHIFT_W] = align_shift[i*SHIFT_W +: SHIFT_W];
          end else if (mo == W0 + ALIGN_TIMEOUT - 1) begin
            if (m_tap + TAP_STEP <= TAP_MAX) begin
              m_tap = m_tap + TAP_STEP;
              m_att = (m_att < 15) ? m_att + 1 : 15;
              base  = t + 1;
            end else begin
              m_run = 0; m_fail = 1; m_fm = m_mask & ~align_done;
            end
          end
        end
      end
      t++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      int eo, e_state;
      bit e_rst, e_ld, e_as;
      @(negedge clk);
      if (m_valid) begin
        e_rst = 0; e_ld = 0; e_as = 0; e_state = 0;
        if (m_run) begin
          eo = t - base;
          e_rst = (eo < R);
          e_ld  = (eo == R);
          e_as  = (eo == R + S + 1);
          e_state = (eo < R) ? 1 : (eo == R) ? 2 : (eo <= R + S) ? 3 : (eo == R + S + 1) ? 4 : 5;
        end else begin
          e_state = m_done ? 6 : (m_fail ? 7 : 0);
        end
        check("deser_reset", 64'(deser_reset_o), 64'(e_rst));
        check("dly_tap_ld", 64'(dly_tap_ld_o), 64'(e_ld));
        if (e_ld) check("dly_tap_in", 64'(dly_tap_in_o), 64'(m_tap));
        check("align_start", 64'(align_start_o), 64'(e_as));
        check("busy", 64'(busy_o), 64'(m_run));
        check("seq_done", 64'(seq_done_o), 64'(m_done));
        check("seq_fail", 64'(seq_fail_o), 64'(m_fail));
        check("fail_mask", 64'(fail_mask_o), 64'(m_fm));
        check("attempt_cnt", 64'(attempt_cnt_o), 64'(m_att));
        check("state_out", 64'(state_out_o), 64'(e_state));
        check("locked_tap", 64'(locked_tap_o), 64'(m_locked));
        check("shift_cap", 64'(shift_cap_o), 64'(m_shift));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [11:0] en);
    @(posedge clk); #1;
    ch_enable = en; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int k;
    k = 0;
    while (!(seq_done_o || seq_fail_o) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_finished"}, 64'(k < budget), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  int s_rst, s_ld, s_bad, k;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("por_state", 64'(state_out_o), 64'(0));
    check("por_tap_in", 64'(dly_tap_in_o), 64'(TAP_INIT));
    check("por_busy", 64'(busy_o), 64'(0));
    $display("run por: state=%0d tap_in=%0d", state_out_o, dly_tap_in_o);

    // all channels align 10 cycles after align_start, shift i on channel i
    mode = 1;
    for (int i = 0; i < NUM_CH; i++) align_shift[i*SHIFT_W +: SHIFT_W] = SHIFT_W'(i);
    s_rst = rst_pulses; s_ld = ld_pulses; s_bad = rst_badlen;
    do_start(12'hFFF);
    wait_end("t1", 200);
    check("t1_done", 64'(seq_done_o), 64'(1));
    check("t1_locked", 64'(locked_tap_o), 64'(0));
    check("t1_attempts", 64'(attempt_cnt_o), 64'(1));
    check("t1_shift", 64'(shift_cap_o), 64'h05A9_2839_8A41_8820);
    check("t1_ld_pulses", 64'(ld_pulses - s_ld), 64'(1));
    $display("run t1: done=%0d tap=%0d attempts=%0d", seq_done_o, locked_tap_o, attempt_cnt_o);

    // channel 5 only aligns from tap 6 upward
    mode = 2;
    s_rst = rst_pulses; s_ld = ld_pulses; s_bad = rst_badlen;
    do_start(12'hFFF);
    wait_end("t2", 1500);
    check("t2_done", 64'(seq_done_o), 64'(1));
    check("t2_locked", 64'(locked_tap_o), 64'(6));
    check("t2_attempts", 64'(attempt_cnt_o), 64'(4));
    check("t2_rst_pulses", 64'(rst_pulses - s_rst), 64'(4));
    check("t2_rst_len", 64'(rst_badlen - s_bad), 64'(0));
    $display("run t2: done=%0d tap=%0d attempts=%0d", seq_done_o, locked_tap_o, attempt_cnt_o);

    // channel 4 never aligns: full sweep, then failure
    mode = 3;
    s_rst = rst_pulses; s_ld = ld_pulses;
    do_start(12'h0F0);
    wait_end("t3", 6000);
    check("t3_fail", 64'(seq_fail_o), 64'(1));
    check("t3_fail_mask", 64'(fail_mask_o), 64'h010);
    check("t3_attempts", 64'(attempt_cnt_o), 64'(15));
    check("t3_ld_pulses", 64'(ld_pulses - s_ld), 64'(16));
    $display("run t3: fail=%0d mask=0x%0h attempts=%0d", seq_fail_o, fail_mask_o, attempt_cnt_o);

    // only channels 0,1 enabled; the rest stay low and must capture 0
    mode = 4;
    align_shift = '1;
    do_start(12'h003);
    wait_end("t4", 200);
    check("t4_done", 64'(seq_done_o), 64'(1));
    check("t4_shift", 64'(shift_cap_o), 64'h3FF);
    $display("run t4: done=%0d shift=0x%0h", seq_done_o, shift_cap_o);

    // start during WAIT is ignored; reset 3 cycles into the next SETTLE
    mode = 0;
    do_start(12'hFFF);
    k = 0;
    while (!align_start_o && k < 100) begin @(negedge clk); k++; end
    check("t5_align_seen", 64'(k < 100), 64'(1));
    repeat (3) @(negedge clk);
    do_start(12'h00F);
    @(negedge clk);
    check("t5_busy_kept", 64'(busy_o), 64'(1));
    check("t5_attempt_kept", 64'(attempt_cnt_o), 64'(1));
    k = 0;
    while (!(state_out_o == 3'd3 && attempt_cnt_o == 4'd2) && k < 600) begin @(negedge clk); k++; end
    check("t5_settle_seen", 64'(k < 600), 64'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5_rst_state", 64'(state_out_o), 64'(0));
    check("t5_rst_deser", 64'(deser_reset_o), 64'(0));
    check("t5_rst_attempt", 64'(attempt_cnt_o), 64'(0));
    check("t5_rst_tap_in", 64'(dly_tap_in_o), 64'(TAP_INIT));
    check("t5_rst_busy", 64'(busy_o), 64'(0));
    mode = 1;
    do_start(12'hFFF);
    wait_end("t5", 200);
    check("t5_done", 64'(seq_done_o), 64'(1));
    check("t5_attempts", 64'(attempt_cnt_o), 64'(1));
    $display("run t5: done=%0d attempts=%0d", seq_done_o, attempt_cnt_o);

    // done bits never all high together until since=20
    mode = 5;
    do_start(12'hFFF);
    wait_end("t5b", 200);
    check("t5b_done", 64'(seq_done_o), 64'(1));
    check("t5b_attempts", 64'(attempt_cnt_o), 64'(1));
    $display("run t5b: done=%0d attempts=%0d", seq_done_o, attempt_cnt_o);

    // success on the very cycle the timeout expires
    mode = 6;
    s_rst = rst_pulses;
    do_start(12'hFFF);
    wait_end("t5c", 600);
    check("t5c_done", 64'(seq_done_o), 64'(1));
    check("t5c_attempts", 64'(attempt_cnt_o), 64'(1));
    check("t5c_rst_pulses", 64'(rst_pulses - s_rst), 64'(1));
    $display("run t5c: done=%0d attempts=%0d", seq_done_o, attempt_cnt_o);

    // empty enable mask fails at once with no deserializer reset
    mode = 1;
    s_rst = rst_pulses;
    do_start(12'h000);
    @(negedge clk);
    check("t6_fail", 64'(seq_fail_o), 64'(1));
    check("t6_fail_mask", 64'(fail_mask_o), 64'(0));
    check("t6_state", 64'(state_out_o), 64'(7));
    repeat (20) @(negedge clk);
    check("t6_rst_pulses", 64'(rst_pulses - s_rst), 64'(0));
    $display("run t6: fail=%0d mask=0x%0h", seq_fail_o, fail_mask_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, expected completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
